// File: rtl/inst_fetch_pkg.sv
// Shared constants and payload types for the instruction fetch stage.
package inst_fetch_pkg;

  localparam logic [31:0] INST_NOP         = 32'h0000_0013;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
  localparam logic [31:0] PC_STEP          = 32'd4;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
  } fetch_entry_t;

  function automatic logic [31:0] align_pc(input logic [31:0] pc);
    return pc & ~32'h0000_0003;
  endfunction

endpackage

// File: rtl/inst_fetch_sync_fifo.sv
// Synchronous FIFO with flush; push and pop may coincide at any occupancy.
module sync_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush_i,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           push_data_i,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           head_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    rd_q;
  logic [AW-1:0]    wr_q;
  logic [CW-1:0]    cnt_q;
  logic             do_pop;
  logic             do_push;

  function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  // A pop frees the slot a same-cycle push needs when full.
  assign do_pop  = pop_i && (cnt_q != '0);
  assign do_push = push_i && ((cnt_q != CW'(DEPTH)) || do_pop);

  assign head_o  = mem_q[rd_q];
  assign count_o = cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
    end else if (flush_i) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_q] <= push_data_i;
        wr_q        <= next_ptr(wr_q);
      end
      if (do_pop) rd_q <= next_ptr(rd_q);
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + CW'(1);
        2'b01:   cnt_q <= cnt_q - CW'(1);
        default: ;
      endcase
      assert (!(push_i && !do_push));
    end
  end

endmodule

// File: rtl/inst_fetch.sv
// Fetch stage: issues PC requests under a credit limit, buffers returned words
// with their PCs for decode, and drops stale responses after a redirect.
module inst_fetch
  import inst_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC        = DEFAULT_RESET_PC,
  parameter int unsigned FIFO_DEPTH      = 2,
  parameter int unsigned MAX_OUTSTANDING = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc
);

  localparam int unsigned CW  = $clog2(MAX_OUTSTANDING + 1);
  localparam int unsigned FCW = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned EW  = $bits(fetch_entry_t);

  logic [31:0]   pc_q, pc_d;
  logic [CW-1:0] outst_q, outst_d;
  logic [CW-1:0] discard_q, discard_d;

  logic          req_fire;
  logic          rsp_keep;
  logic [31:0]   pcq_head;
  logic [CW-1:0] pcq_count;
  logic [FCW-1:0] buf_count;
  fetch_entry_t  buf_push_data;
  fetch_entry_t  buf_head;

  // Every live token (buffered, or owed and not discarded) holds a buffer slot.
  assign imem_req_valid = !rst && !redirect_valid
                          && ((32'(buf_count) + 32'(outst_q) - 32'(discard_q)) < FIFO_DEPTH)
                          && (32'(outst_q) < MAX_OUTSTANDING);
  assign imem_req_addr  = pc_q;
  assign req_fire       = imem_req_valid && imem_req_ready;
  assign rsp_keep       = imem_rsp_valid && !redirect_valid && (discard_q == '0);

  always_comb begin
    pc_d      = pc_q;
    outst_d   = outst_q;
    discard_d = discard_q;
    if (req_fire) pc_d = pc_q + PC_STEP;
    case ({req_fire, imem_rsp_valid})
      2'b10:   outst_d = outst_q + CW'(1);
      2'b01:   outst_d = outst_q - CW'(1);
      default: ;
    endcase
    if (imem_rsp_valid && (discard_q != '0)) discard_d = discard_q - CW'(1);
    // Redirect: every response still owed after this cycle gets dropped.
    if (redirect_valid) begin
      pc_d      = align_pc(redirect_pc);
      discard_d = imem_rsp_valid ? outst_q - CW'(1) : outst_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q      <= RESET_PC;
      outst_q   <= '0;
      discard_q <= '0;
    end else begin
      pc_q      <= pc_d;
      outst_q   <= outst_d;
      discard_q <= discard_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && imem_rsp_valid) assert (pcq_count != '0);
    if (!rst) assert (pcq_count == outst_q);
  end

  sync_fifo #(
    .WIDTH (32),
    .DEPTH (MAX_OUTSTANDING)
  ) u_pc_queue (
    .clk         (clk),
    .rst         (rst),
    .flush_i     (1'b0),
    .push_i      (req_fire),
    .push_data_i (pc_q),
    .pop_i       (imem_rsp_valid),
    .head_o      (pcq_head),
    .count_o     (pcq_count)
  );

  assign buf_push_data = fetch_entry_t'{inst: imem_rsp_data, pc: pcq_head};

  sync_fifo #(
    .WIDTH (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_inst_buf (
    .clk         (clk),
    .rst         (rst),
    .flush_i     (redirect_valid),
    .push_i      (rsp_keep),
    .push_data_i (buf_push_data),
    .pop_i       (inst_ready),
    .head_o      (buf_head),
    .count_o     (buf_count)
  );

  assign inst_valid = (buf_count != '0);
  assign inst       = buf_head.inst;
  assign inst_pc    = buf_head.pc;

endmodule
